arm_mem_arbiter: RTL
====================

# arm_mem_arbiter

Parametrised shared-memory arbiter between the pipelined ARM core's instruction-fetch port and its data port, replacing the split instruction/data memory arrangement with a single variable-latency memory. It grants one access at a time over a request/acknowledge memory handshake, returns read data and a one-cycle ready to the granted port, and aborts stuck accesses after a programmable timeout. It sits directly below the core top level, between the pipelined datapath and the memory model.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; must be a multiple of 8
- TIMEOUT, 16, cycles to wait for m_ack before aborting; 0 disables timeout

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- i_req  input  1  instruction fetch request, held until i_ready
- i_addr  input  ADDR_W  fetch address (PC)
- i_rdata  output  DATA_W  fetched instruction, valid with i_ready
- i_ready  output  1  one-cycle completion pulse for fetch
- d_req  input  1  data request, held until d_ready
- d_we  input  1  1 = store, 0 = load
- d_be  input  DATA_W/8  byte enables for stores
- d_addr  input  ADDR_W  data address (ALUResult)
- d_wdata  input  DATA_W  store data
- d_rdata  output  DATA_W  load data, valid with d_ready
- d_ready  output  1  one-cycle completion pulse for data access
- m_req  output  1  memory request, held until m_ack or timeout
- m_we  output  1  memory write strobe
- m_be  output  DATA_W/8  memory byte enables
- m_addr  output  ADDR_W  memory address
- m_wdata  output  DATA_W  memory write data
- m_rdata  input  DATA_W  memory read data, valid with m_ack
- m_ack  input  1  memory completion, sampled only while m_req = 1
- err  output  1  one-cycle pulse, coincident with ready, on timeout abort

## Operation
- FSM states: IDLE, IBUS, DBUS, DONE.
- IDLE: if d_req or i_req, select winner, register m_* from winner, go IBUS/DBUS. Default priority: data over instruction when both pending.
- IBUS: m_req=1, m_we=0, m_be=all ones, m_addr=i_addr (registered), m_wdata=0.
- DBUS: m_req=1, m_we=d_we, m_be=d_be, m_addr=d_addr, m_wdata=d_wdata (all registered at grant).
- IBUS/DBUS with m_ack=1: capture m_rdata into i_rdata/d_rdata, drop m_req, pulse matching ready, go DONE.
- Timeout: counter cleared on grant, increments each IBUS/DBUS cycle without m_ack; when count reaches TIMEOUT-1 with m_ack=0, drop m_req, load rdata with 0, pulse matching ready and err, go DONE. m_ack in that same cycle wins (normal completion, no err).
- DONE: single cycle, requests ignored (requester still holds req while seeing ready), then IDLE.
- i_rdata/d_rdata hold last captured value until next completion on that port.
- Store completion pulses d_ready; d_rdata updated with m_rdata regardless.
- Requests changing mid-access are ignored; only registered values drive memory.

## Timing
- Reset (asynchronous, active-low): state=IDLE, all outputs 0, counters and rdata registers 0, round-robin pointer points to data. m_req drops immediately on reset assertion, aborting any access without ready.
- Minimum latency: req seen in cycle 0, m_req high cycle 1, m_ack in cycle 1 -> ready high cycle 2, DONE cycle 2, IDLE cycle 3.
- Maximum back-to-back throughput: one access every 3 cycles.
- Ready and err are single-cycle pulses; never asserted in IDLE or during reset.
- m_* outputs stable for entire m_req high interval.

## Configuration
- ARM_ARB_ROUNDROBIN_EN defined: when both requests pending in IDLE, grant the port not granted most recently; single-port requests granted unconditionally and update the pointer.
- Undefined: fixed data-over-instruction priority; pointer logic absent.

## Test plan
- Single fetch: i_req=1, i_addr=0x100, memory acks 1 cycle after m_req with 0xE3A00001 -> m_addr=0x100, m_we=0, m_be=0xF, i_ready pulse cycle 2, i_rdata=0xE3A00001.
- Byte store: d_req=1, d_we=1, d_be=0x4, d_addr=0x20, d_wdata=0x00AB0000, ack after 3 cycles -> m_we=1, m_be=0x4 for 3 cycles, d_ready one pulse, err=0.
- Contention: i_req and d_req together, held 3 accesses -> fixed: D,D,D while d_req held, then I; with ARM_ARB_ROUNDROBIN_EN: D,I,D.
- Timeout: TIMEOUT=4, m_ack tied 0 -> m_req high 4 cycles, d_ready and err pulse together, d_rdata=0, FSM back to IDLE after DONE.
- Timeout tie: m_ack arrives in cycle count=TIMEOUT-1 with 0x55 -> normal completion, rdata=0x55, err=0.
- Reset mid-access: assert reset while m_req=1 -> m_req, ready, err all 0 immediately; after release, fresh i_req completes normally.

Source files
------------

// File: rtl/arm_mem_arbiter.sv
// arm_mem_arbiter: shares one variable-latency memory between the instruction
// fetch port and the data port. One access at a time, registered memory
// request, one-cycle ready per port, and a timeout abort that flags err.
// Optional feature macro: ARM_ARB_ROUNDROBIN_EN. When it is defined, the port
// not granted most recently wins a tie. When it is undefined, data wins a tie.
module arm_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack,
    output logic                err
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Final count value before the abort; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, IBUS, DBUS, DONE} state_t;

    state_t              state_reg, state_next;
    logic                m_req_reg, m_req_next;
    logic                m_we_reg, m_we_next;
    logic [BE_W-1:0]     m_be_reg, m_be_next;
    logic [ADDR_W-1:0]   m_addr_reg, m_addr_next;
    logic [DATA_W-1:0]   m_wdata_reg, m_wdata_next;
    logic [DATA_W-1:0]   i_rdata_reg, i_rdata_next;
    logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
    logic                i_ready_reg, i_ready_next;
    logic                d_ready_reg, d_ready_next;
    logic                err_reg, err_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                grant_d;
    logic                timeout_hit;

`ifdef ARM_ARB_ROUNDROBIN_EN
    // 1 = data port is preferred on the next tie.
    logic                rr_data_reg, rr_data_next;

    // Tie goes to the port that was not served last; a lone request always wins.
    assign grant_d = d_req && (!i_req || rr_data_reg);
`else
    // Fixed priority: data beats instruction fetch.
    assign grant_d = d_req;
`endif

    // Abort fires on the last allowed wait cycle; TIMEOUT of 0 never aborts.
    assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == CNT_LAST);

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_next   = state_reg;
        m_req_next   = m_req_reg;
        m_we_next    = m_we_reg;
        m_be_next    = m_be_reg;
        m_addr_next  = m_addr_reg;
        m_wdata_next = m_wdata_reg;
        i_rdata_next = i_rdata_reg;
        d_rdata_next = d_rdata_reg;
        i_ready_next = 1'b0;
        d_ready_next = 1'b0;
        err_next     = 1'b0;
        cnt_next     = cnt_reg;
`ifdef ARM_ARB_ROUNDROBIN_EN
        rr_data_next = rr_data_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (d_req || i_req) begin
                    m_req_next = 1'b1;
                    cnt_next   = '0;
`ifdef ARM_ARB_ROUNDROBIN_EN
                    rr_data_next = !grant_d;
`endif
                    if (grant_d) begin
                        state_next   = DBUS;
                        m_we_next    = d_we;
                        m_be_next    = d_be;
                        m_addr_next  = d_addr;
                        m_wdata_next = d_wdata;
                    end else begin
                        state_next   = IBUS;
                        m_we_next    = 1'b0;
                        m_be_next    = '1;
                        m_addr_next  = i_addr;
                        m_wdata_next = '0;
                    end
                end
            end
            IBUS, DBUS: begin
                // An ack in the final timeout cycle still counts as success.
                if (m_ack || timeout_hit) begin
                    m_req_next = 1'b0;
                    state_next = DONE;
                    err_next   = !m_ack;
                    if (state_reg == IBUS) begin
                        i_rdata_next = m_ack ? m_rdata : '0;
                        i_ready_next = 1'b1;
                    end else begin
                        d_rdata_next = m_ack ? m_rdata : '0;
                        d_ready_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                // Requester still holds req while it sees ready; skip a cycle.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset drops m_req at once, mid-access or not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            m_req_reg   <= 1'b0;
            m_we_reg    <= 1'b0;
            m_be_reg    <= '0;
            m_addr_reg  <= '0;
            m_wdata_reg <= '0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
            i_ready_reg <= 1'b0;
            d_ready_reg <= 1'b0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
`ifdef ARM_ARB_ROUNDROBIN_EN
            rr_data_reg <= 1'b1;
`endif
        end else begin
            state_reg   <= state_next;
            m_req_reg   <= m_req_next;
            m_we_reg    <= m_we_next;
            m_be_reg    <= m_be_next;
            m_addr_reg  <= m_addr_next;
            m_wdata_reg <= m_wdata_next;
            i_rdata_reg <= i_rdata_next;
            d_rdata_reg <= d_rdata_next;
            i_ready_reg <= i_ready_next;
            d_ready_reg <= d_ready_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
`ifdef ARM_ARB_ROUNDROBIN_EN
            rr_data_reg <= rr_data_next;
`endif
        end
    end

    assign m_req   = m_req_reg;
    assign m_we    = m_we_reg;
    assign m_be    = m_be_reg;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;
    assign i_rdata = i_rdata_reg;
    assign d_rdata = d_rdata_reg;
    assign i_ready = i_ready_reg;
    assign d_ready = d_ready_reg;
    assign err     = err_reg;

endmodule
